// File: rtl/lsu_pkg.sv
// Shared load/store encodings, FSM states and access-size helpers for mem_lsu.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    return lsu_size_e'(f3[1:0]);
  endfunction

  // Stores only use the signed encodings; 64-bit-only accesses are illegal on RV32.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3,
                                    input logic xlen64);
    if (is_store)
      return (f3[2] == 1'b0) && (xlen64 || (f3 != F3_D));
    else if (f3 == 3'b111)
      return 1'b0;
    else if (!xlen64 && ((f3 == F3_D) || (f3 == F3_WU)))
      return 1'b0;
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module mem_lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic [2:0]      i_funct3,
  input  logic [OFFW-1:0] i_offset,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  // funct3[2] selects the unsigned variant
  always_comb begin
    o_data = w_shifted;
    case (f3_size(i_funct3))
      SZ_B: o_data = i_funct3[2] ? XLEN'(w_shifted[7:0])
                                 : XLEN'($signed(w_shifted[7:0]));
      SZ_H: o_data = i_funct3[2] ? XLEN'(w_shifted[15:0])
                                 : XLEN'($signed(w_shifted[15:0]));
      SZ_W: o_data = i_funct3[2] ? XLEN'(w_shifted[31:0])
                                 : XLEN'($signed(w_shifted[31:0]));
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit: IDLE->REQ->(WAIT)->IDLE, done 2 cycles (store) / 3 cycles (load) after accept.
// Optional MEM_LSU_MISALIGN_TRAP_EN rejects unaligned half/word/dword accesses instead of aligning them down.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [XLEN-1:0]   wdata_o,
  input  logic              rvalid_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              done_o,
  output logic              wb_wen_o,
  output logic [4:0]        rd_addr_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              misalign_o
);

  localparam int NB   = XLEN/8;
  localparam int OFFW = $clog2(NB);

  lsu_state_e        r_state, w_state_nxt;
  logic              r_is_store;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_offset;
  logic [ADDR_W-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [4:0]        r_op_rd;
  logic              r_flushed;
  logic              r_done;
  logic              r_wb_wen;
  logic [4:0]        r_rd_addr;
  logic [XLEN-1:0]   r_rd_data;

  lsu_size_e         w_size;
  logic [OFFW-1:0]   w_size_mask;
  logic [OFFW-1:0]   w_offset;
  logic [NB-1:0]     w_lane_mask;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata;
  logic [ADDR_W-1:0] w_addr_al;
  logic              w_legal;
  logic [XLEN-1:0]   w_ld_data;
  logic [4:0]        w_rd_sel;
  logic              w_accept;
  logic              w_done_nxt;
  logic              w_wen_nxt;
  logic              w_res_load;
  logic              w_res_zero;
  logic              w_flushed_nxt;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  logic              w_misalign;
  logic              w_mis_nxt;
  logic              r_misalign;
  assign w_misalign = |(addr_i[OFFW-1:0] & w_size_mask);
`endif

  // ---------------- accept-time decode ----------------
  assign w_size  = f3_size(funct3_i);
  assign w_legal = f3_legal(is_store_i, funct3_i, XLEN == 64);

  always_comb begin
    w_size_mask = '0;
    w_lane_mask = '1;
    w_wdata     = wdata_i;
    case (w_size)
      SZ_B: begin
        w_size_mask = OFFW'(3'd0);
        w_lane_mask = NB'(8'h01);
        w_wdata     = {NB{wdata_i[7:0]}};
      end
      SZ_H: begin
        w_size_mask = OFFW'(3'd1);
        w_lane_mask = NB'(8'h03);
        w_wdata     = {(NB/2){wdata_i[15:0]}};
      end
      SZ_W: begin
        w_size_mask = OFFW'(3'd3);
        w_lane_mask = NB'(8'h0F);
        w_wdata     = {(NB/4){wdata_i[31:0]}};
      end
      default: begin
        w_size_mask = OFFW'(3'd7);
        w_lane_mask = '1;
        w_wdata     = wdata_i;
      end
    endcase
  end

  // Unaligned low bits are dropped so the access lands on its natural boundary.
  assign w_offset  = addr_i[OFFW-1:0] & ~w_size_mask;
  assign w_be      = w_lane_mask << w_offset;
  assign w_addr_al = {addr_i[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign w_rd_sel  = (r_state == ST_IDLE) ? rd_addr_i : r_op_rd;

  mem_lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .i_funct3 (r_funct3),
    .i_offset (r_offset),
    .i_rdata  (rdata_i),
    .o_data   (w_ld_data)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_done_nxt    = 1'b0;
    w_wen_nxt     = 1'b0;
    w_res_load    = 1'b0;
    w_res_zero    = 1'b0;
    w_flushed_nxt = r_flushed;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    w_mis_nxt     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // An op presented together with flush is consumed and silently dropped.
        if (valid_i && !flush_i) begin
          w_accept = 1'b1;
          if (!w_legal) begin
            w_done_nxt = 1'b1;
            w_res_zero = 1'b1;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
          end else if (w_misalign) begin
            w_done_nxt = 1'b1;
            w_mis_nxt  = 1'b1;
            w_res_zero = 1'b1;
`endif
          end else begin
            w_state_nxt   = ST_REQ;
            w_flushed_nxt = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (gnt_i) begin
          if (r_is_store) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = !flush_i;
          end else begin
            w_state_nxt   = ST_WAIT;
            w_flushed_nxt = flush_i;
          end
        end else if (flush_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A granted load must still drain its response even when killed.
        if (flush_i) w_flushed_nxt = 1'b1;
        if (rvalid_i) begin
          w_state_nxt = ST_IDLE;
          if (!r_flushed && !flush_i) begin
            w_done_nxt = 1'b1;
            w_wen_nxt  = 1'b1;
            w_res_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_is_store <= 1'b0;
      r_funct3   <= '0;
      r_offset   <= '0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_op_rd    <= '0;
      r_flushed  <= 1'b0;
      r_done     <= 1'b0;
      r_wb_wen   <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
    end else begin
      r_flushed <= w_flushed_nxt;
      r_done    <= w_done_nxt;
      r_wb_wen  <= w_wen_nxt;
      if (w_accept) begin
        r_is_store <= is_store_i;
        r_funct3   <= funct3_i;
        r_offset   <= w_offset;
        r_addr     <= w_addr_al;
        r_be       <= w_be;
        r_wdata    <= w_wdata;
        r_op_rd    <= rd_addr_i;
      end
      if (w_done_nxt) r_rd_addr <= w_rd_sel;
      if (w_res_load)      r_rd_data <= w_ld_data;
      else if (w_res_zero) r_rd_data <= '0;
    end
  end

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_misalign <= 1'b0;
    else       r_misalign <= w_mis_nxt;
  end
  assign misalign_o = r_misalign;
`else
  assign misalign_o = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign ready_o   = (r_state == ST_IDLE);
  assign req_o     = (r_state == ST_REQ);
  assign we_o      = req_o && r_is_store;
  assign be_o      = req_o ? r_be    : '0;
  assign addr_o    = req_o ? r_addr  : '0;
  assign wdata_o   = req_o ? r_wdata : '0;
  assign done_o    = r_done;
  assign wb_wen_o  = r_wb_wen;
  assign rd_addr_o = r_rd_addr;
  assign rd_data_o = r_rd_data;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/register width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Port clk  input  1  sole clock, rising edge; one clock domain.
REQ-004 Port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 Ports valid_i/ready_o  in/out  1/1  pipeline handshake; transfer accepted when both high at a clk edge.
REQ-006 Ports is_store_i  in  1, funct3_i  in  3, addr_i  in  ADDR_W, wdata_i  in  XLEN, rd_addr_i  in  5  accepted op fields.
REQ-007 Port flush_i  input  1  kill the in-flight op.
REQ-008 Bus ports req_o out 1, gnt_i in 1, we_o out 1, be_o out XLEN/8, addr_o out ADDR_W, wdata_o out XLEN, rvalid_i in 1, rdata_i in XLEN.
REQ-009 Result ports done_o out 1, wb_wen_o out 1, rd_addr_o out 5, rd_data_o out XLEN, misalign_o out 1.

Function
REQ-010 FSM states IDLE, REQ, WAIT; ready_o=1 only in IDLE.
REQ-011 IDLE + accept: register op fields; to REQ (next cycle req_o=1).
REQ-012 REQ: req_o, we_o, be_o, addr_o, wdata_o held stable until gnt_i=1; store+gnt -> IDLE, done_o=1 next cycle; load+gnt -> WAIT.
REQ-013 WAIT: on rvalid_i, extracted load data registered to rd_data_o, done_o=1 and wb_wen_o=1 for one cycle, -> IDLE.
REQ-014 Minimum latency: accept at edge N, gnt in N+1, rvalid in N+2 -> done_o high in N+3; store done_o high in N+2.
REQ-015 addr_o = word-aligned address (low log2(XLEN/8) bits zero); be_o = size mask shifted by low address bits (SB 1 lane, SH 2, SW 4, SD all).
REQ-016 wdata_o = store byte/half/word replicated across all lanes.
REQ-017 Load extraction: LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD full; lane selected by low address bits; XLEN=32 treats LWU/LD/SD as illegal.
REQ-018 Illegal funct3: no bus request; done_o=1 next cycle, wb_wen_o=0, rd_data_o=0.
REQ-019 flush_i in IDLE/REQ before grant: drop request (req_o=0 next cycle), -> IDLE, no done_o.
REQ-020 flush_i in WAIT: remain until rvalid_i, then -> IDLE with done_o=0, wb_wen_o=0.
REQ-021 flush_i coincident with gnt_i: grant honoured; store completes silently (done_o=0); load follows REQ-020.
REQ-022 gnt_i outside REQ and rvalid_i outside WAIT are ignored.
REQ-023 done_o, wb_wen_o, misalign_o are single-cycle pulses; rd_addr_o/rd_data_o hold until next done_o.

Reset
REQ-024 rstn low: state IDLE, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, done_o=0, wb_wen_o=0, misalign_o=0, rd_addr_o=0, rd_data_o=0.
REQ-025 Reset mid-transaction abandons it; no response generated after release.

Configuration
REQ-026 Macro MEM_LSU_MISALIGN_TRAP_EN defined: half/word/dword access not naturally aligned -> no bus request, done_o=1 and misalign_o=1 next cycle, wb_wen_o=0.
REQ-027 Macro undefined: misaligned address aligned down to access size and executed normally; misalign_o tied 0.

Structure
REQ-028 Shared package lsu_pkg holds funct3 load/store encodings, FSM state encoding, access-size enum.
REQ-029 Sub-module mem_lsu_load_align: combinational lane select plus sign/zero extension, parametrised by XLEN.

Verification
REQ-030 LB, addr 0x1003, rdata 0x80FF_FF11, gnt/rvalid immediate -> rd_data_o=0xFFFF_FF80, wb_wen_o pulse at N+3.
REQ-031 SH, addr 0x2002, wdata 0x0000_BEEF -> be_o=4'b1100, wdata_o=0xBEEF_BEEF, addr_o=0x2000, done_o at N+2, wb_wen_o=0.
REQ-032 LW with gnt delayed 3 cycles, rvalid delayed 2 more -> bus outputs stable throughout REQ, done_o at N+7.
REQ-033 LHU addr 0x3001: TRAP_EN -> req_o never high, misalign_o=1 at N+1; no macro -> addr_o=0x3000, be_o=4'b0011.
REQ-034 flush_i asserted in WAIT -> rvalid accepted, done_o=0, wb_wen_o=0, ready_o=1 next cycle.
REQ-035 XLEN=64, LD addr 0x8, rdata 0x8000_0000_0000_0001 -> rd_data_o equal, be_o=8'hFF; rstn pulse during WAIT -> all outputs 0, state IDLE.
